// File: rtl/biriscv_csr_wb.sv
// CSR E2 stage and writeback request: carries the E1 CSR result one stage, merges late LSU
// faults / interrupts, and raises flush. BIRISCV_CSR_WB_PERF_EN builds the retired counter.
module biriscv_csr_wb #(
    parameter int EXCEPTION_W       = 6,
    parameter int SUPPORT_LSU_FAULT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   e1_valid_i,
    input  logic [31:0]            e1_pc_i,
    input  logic [31:0]            e1_opcode_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [31:0]            csr_result_e1_wdata_i,
    input  logic [31:0]            csr_result_e1_value_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic                   stall_i,
    input  logic                   squash_e1_i,
    input  logic [EXCEPTION_W-1:0] lsu_exception_i,
    input  logic [31:0]            lsu_addr_i,
    input  logic                   take_interrupt_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic                   flush_o,
    output logic [31:0]            perf_retired_o
);

    localparam logic [EXCEPTION_W-1:0] EXC_NONE      = '0;
    localparam logic [EXCEPTION_W-1:0] EXC_ILLEGAL   = EXCEPTION_W'(6'h12);
    localparam logic [EXCEPTION_W-1:0] EXC_INTERRUPT = EXCEPTION_W'(6'h20);

    // Only the CSR address field of the opcode is carried forward.
    logic [19:0] unused_opcode;
    assign unused_opcode = e1_opcode_i[19:0];

    // E2 stage
    logic                   e2_valid_q;
    logic [31:0]            e2_pc_q;
    logic [11:0]            e2_addr_q;
    logic                   e2_write_q;
    logic [31:0]            e2_wdata_q;
    logic [31:0]            e2_value_q;
    logic [EXCEPTION_W-1:0] e2_exc_q;

    // WB stage
    logic                   wb_valid_q;
    logic [31:0]            wb_pc_q;
    logic [11:0]            wb_addr_q;
    logic                   wb_write_q;
    logic [31:0]            wb_wdata_q;
    logic [EXCEPTION_W-1:0] wb_exc_q;
    logic [31:0]            wb_tval_q;

    logic                   flush;
    logic                   wb_load;
    logic [EXCEPTION_W-1:0] merge_exc;
    logic [31:0]            merge_tval;

    // Advance semantics: stall_i=0 moves E1->E2 and E2->WB in the same cycle; there is no
    // per-stage ready. A flush from WB kills both the E2 occupant and the E1 instruction.
    assign flush   = (wb_exc_q != EXC_NONE);
    assign wb_load = ~stall_i & e2_valid_q & ~flush;

    always_comb begin
        merge_exc  = EXC_NONE;
        merge_tval = '0;
        if (e2_exc_q != EXC_NONE) begin
            merge_exc = e2_exc_q;
            if (e2_exc_q == EXC_ILLEGAL)
                merge_tval = e2_value_q;
        end else if ((SUPPORT_LSU_FAULT != 0) && (lsu_exception_i != EXC_NONE)) begin
            merge_exc  = lsu_exception_i;
            merge_tval = lsu_addr_i;
        end else if (take_interrupt_i) begin
            merge_exc = EXC_INTERRUPT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e2_valid_q <= 1'b0;
            e2_pc_q    <= '0;
            e2_addr_q  <= '0;
            e2_write_q <= 1'b0;
            e2_wdata_q <= '0;
            e2_value_q <= '0;
            e2_exc_q   <= '0;
        end else if (!stall_i) begin
            e2_valid_q <= e1_valid_i & ~squash_e1_i & ~flush;
            e2_pc_q    <= e1_pc_i;
            e2_addr_q  <= e1_opcode_i[31:20];
            e2_write_q <= csr_result_e1_write_i;
            e2_wdata_q <= csr_result_e1_wdata_i;
            e2_value_q <= csr_result_e1_value_i;
            e2_exc_q   <= csr_result_e1_exception_i;
        end else if (flush) begin
            e2_valid_q <= 1'b0;
        end
    end

    // WB is a single-cycle slot: anything not loaded this cycle becomes an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || !wb_load) begin
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_addr_q  <= '0;
            wb_write_q <= 1'b0;
            wb_wdata_q <= '0;
            wb_exc_q   <= '0;
            wb_tval_q  <= '0;
        end else begin
            wb_valid_q <= 1'b1;
            wb_pc_q    <= e2_pc_q;
            wb_addr_q  <= e2_addr_q;
            wb_write_q <= e2_write_q;
            wb_wdata_q <= e2_wdata_q;
            wb_exc_q   <= merge_exc;
            wb_tval_q  <= merge_tval;
        end
    end

    assign csr_writeback_write_o          = wb_valid_q & wb_write_q & (wb_exc_q == EXC_NONE);
    assign csr_writeback_waddr_o          = wb_addr_q;
    assign csr_writeback_wdata_o          = wb_wdata_q;
    assign csr_writeback_exception_o      = wb_exc_q;
    assign csr_writeback_exception_pc_o   = flush ? wb_pc_q : 32'd0;
    assign csr_writeback_exception_addr_o = wb_tval_q;
    assign flush_o                        = flush;

`ifdef BIRISCV_CSR_WB_PERF_EN
    localparam logic [EXCEPTION_W-1:0] EXC_FENCE = EXCEPTION_W'(6'h34);

    logic [31:0] perf_retired_q;

    always_ff @(posedge clk) begin
        if (rst)
            perf_retired_q <= '0;
        else if (wb_valid_q && (wb_exc_q == EXC_NONE || wb_exc_q == EXC_FENCE))
            perf_retired_q <= perf_retired_q + 32'd1;
    end

    assign perf_retired_o = perf_retired_q;
`else
    assign perf_retired_o = '0;
`endif

endmodule

// File: tb/tb_biriscv_csr_wb.sv
// Self-checking bench for biriscv_csr_wb: directed test-plan cases with literal checks,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_biriscv_csr_wb;

  localparam logic [5:0] EXC_ILLEGAL    = 6'h12;
  localparam logic [5:0] EXC_BREAKPOINT = 6'h13;
  localparam logic [5:0] EXC_MIS_LOAD   = 6'h14;
  localparam logic [5:0] EXC_FAULT_LOAD = 6'h15;
  localparam logic [5:0] EXC_FAULT_ST   = 6'h17;
  localparam logic [5:0] EXC_ECALL      = 6'h18;
  localparam logic [5:0] EXC_INTERRUPT  = 6'h20;
  localparam logic [5:0] EXC_ERET_M     = 6'h33;
  localparam logic [5:0] EXC_FENCE      = 6'h34;
`ifdef BIRISCV_CSR_WB_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        e1_valid;
  logic [31:0] e1_pc, e1_opcode, e1_wdata, e1_value;
  logic        e1_write;
  logic [5:0]  e1_exc;
  logic        stall, squash;
  logic [5:0]  lsu_exc;
  logic [31:0] lsu_addr;
  logic        irq;

  logic        wb_write;
  logic [11:0] wb_waddr;
  logic [31:0] wb_wdata;
  logic [5:0]  wb_exc;
  logic [31:0] wb_exc_pc, wb_exc_addr;
  logic        flush;
  logic [31:0] perf;

  biriscv_csr_wb dut (
    .clk                            (clk),
    .rst                            (rst),
    .e1_valid_i                     (e1_valid),
    .e1_pc_i                        (e1_pc),
    .e1_opcode_i                    (e1_opcode),
    .csr_result_e1_write_i          (e1_write),
    .csr_result_e1_wdata_i          (e1_wdata),
    .csr_result_e1_value_i          (e1_value),
    .csr_result_e1_exception_i      (e1_exc),
    .stall_i                        (stall),
    .squash_e1_i                    (squash),
    .lsu_exception_i                (lsu_exc),
    .lsu_addr_i                     (lsu_addr),
    .take_interrupt_i               (irq),
    .csr_writeback_write_o          (wb_write),
    .csr_writeback_waddr_o          (wb_waddr),
    .csr_writeback_wdata_o          (wb_wdata),
    .csr_writeback_exception_o      (wb_exc),
    .csr_writeback_exception_pc_o   (wb_exc_pc),
    .csr_writeback_exception_addr_o (wb_exc_addr),
    .flush_o                        (flush),
    .perf_retired_o                 (perf)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [11:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] value;
    logic [5:0]  exc;
  } instr_t;

  typedef struct {
    logic        valid;
    logic        write;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [5:0]  exc;
    logic [31:0] pc;
    logic [31:0] tval;
  } retire_t;

  instr_t      m_e2, n_e2;
  retire_t     m_wb, n_wb;
  logic [31:0] m_perf, n_perf;
  int          n_vec = 0;
  int          n_err = 0;

  // What an instruction looks like when it retires, given the late inputs seen at that moment.
  function automatic retire_t retire(input instr_t e, input logic [5:0] lsu,
                                     input logic [31:0] la, input logic take_irq);
    retire_t r;
    r = '{default: '0};
    r.valid = 1'b1;
    if (e.exc != 6'd0) begin
      r.exc  = e.exc;
      r.tval = (e.exc == EXC_ILLEGAL) ? e.value : 32'd0;
    end else if (lsu != 6'd0) begin
      r.exc  = lsu;
      r.tval = la;
    end else if (take_irq) begin
      r.exc = EXC_INTERRUPT;
    end
    r.write = e.write && (r.exc == 6'd0);
    r.waddr = e.addr;
    r.wdata = e.wdata;
    r.pc    = (r.exc != 6'd0) ? e.pc : 32'd0;
    return r;
  endfunction

  task automatic model_next();
    logic   flushing;
    instr_t incoming;
    if (rst) begin
      n_e2   = '{default: '0};
      n_wb   = '{default: '0};
      n_perf = 32'd0;
    end else begin
      flushing = (m_wb.exc != 6'd0);
      n_perf   = m_perf;
      if (PERF_EN && m_wb.valid && (m_wb.exc == 6'd0 || m_wb.exc == EXC_FENCE))
        n_perf = m_perf + 32'd1;
      if (!stall && m_e2.valid && !flushing)
        n_wb = retire(m_e2, lsu_exc, lsu_addr, irq);
      else
        n_wb = '{default: '0};
      incoming = '{valid: e1_valid && !squash && !flushing, pc: e1_pc,
                   addr: e1_opcode[31:20], write: e1_write, wdata: e1_wdata,
                   value: e1_value, exc: e1_exc};
      n_e2 = m_e2;
      if (!stall)
        n_e2 = incoming;
      else if (flushing)
        n_e2.valid = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("write_o",   32'(wb_write),    32'(m_wb.write));
    chk("waddr_o",   32'(wb_waddr),    32'(m_wb.waddr));
    chk("wdata_o",   wb_wdata,         m_wb.wdata);
    chk("exc_o",     32'(wb_exc),      32'(m_wb.exc));
    chk("exc_pc_o",  wb_exc_pc,        m_wb.pc);
    chk("exc_addr_o", wb_exc_addr,     m_wb.tval);
    chk("flush_o",   32'(flush),       32'(m_wb.exc != 6'd0));
    chk("perf_o",    perf,             m_perf);
  endtask

  // One clock: model consumes the current inputs, DUT samples them at posedge,
  // outputs are compared at the following negedge.
  task automatic step();
    model_next();
    @(posedge clk);
    m_e2   = n_e2;
    m_wb   = n_wb;
    m_perf = n_perf;
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 1'b0; e1_valid = 1'b0; e1_pc = '0; e1_opcode = '0; e1_write = 1'b0;
    e1_wdata = '0; e1_value = '0; e1_exc = '0; stall = 1'b0; squash = 1'b0;
    lsu_exc = '0; lsu_addr = '0; irq = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [11:0] csr,
                             input logic wr, input logic [31:0] wd,
                             input logic [31:0] val, input logic [5:0] exc);
    e1_valid = 1'b1; e1_pc = pc; e1_opcode = {csr, 20'h02073}; e1_write = wr;
    e1_wdata = wd; e1_value = val; e1_exc = exc;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    int r;
    set_idle();
    rst      = ($urandom_range(0, 149) == 0);
    e1_valid = ($urandom_range(0, 3) != 0);
    e1_pc    = $urandom() & 32'hFFFF_FFFC;
    e1_opcode = $urandom();
    e1_write = $urandom_range(0, 1) == 1;
    e1_wdata = $urandom();
    e1_value = $urandom();
    r = $urandom_range(0, 19);
    case (r)
      0: e1_exc = EXC_ILLEGAL;
      1: e1_exc = EXC_ECALL;
      2: e1_exc = EXC_FENCE;
      3: e1_exc = EXC_ERET_M;
      4: e1_exc = EXC_BREAKPOINT;
      default: e1_exc = 6'd0;
    endcase
    stall  = ($urandom_range(0, 3) == 0);
    squash = ($urandom_range(0, 9) == 0);
    r = $urandom_range(0, 11);
    case (r)
      0: lsu_exc = EXC_FAULT_LOAD;
      1: lsu_exc = EXC_FAULT_ST;
      2: lsu_exc = EXC_MIS_LOAD;
      default: lsu_exc = 6'd0;
    endcase
    lsu_addr = $urandom();
    irq      = ($urandom_range(0, 11) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_e2 = '{default: '0}; n_e2 = '{default: '0};
    m_wb = '{default: '0}; n_wb = '{default: '0};
    m_perf = '0; n_perf = '0;
    set_idle();
    rst = 1'b1;
    step();
    step();
    chk("reset_write", 32'(wb_write), 32'd0);
    chk("reset_flush", 32'(flush), 32'd0);
    rst = 1'b0;

    // CSR write, two-cycle latency
    drive_instr(32'h8000_0000, 12'h300, 1'b1, 32'h0000_1888, 32'h0, 6'd0);
    step();
    set_idle();
    step();
    chk("csrw_write", 32'(wb_write), 32'd1);
    chk("csrw_waddr", 32'(wb_waddr), 32'h300);
    chk("csrw_wdata", wb_wdata, 32'h0000_1888);
    chk("csrw_exc",   32'(wb_exc), 32'd0);
    chk("csrw_flush", 32'(flush), 32'd0);
    step();
    chk("csrw_single_pulse", 32'(wb_write), 32'd0);

    // Illegal instruction followed by a younger write that must never retire
    drive_instr(32'h8000_0010, 12'h305, 1'b0, 32'h0, 32'hFFFF_FFFF, EXC_ILLEGAL);
    step();
    drive_instr(32'h8000_0014, 12'h340, 1'b1, 32'hAAAA_5555, 32'h0, 6'd0);
    step();
    drive_instr(32'h8000_0018, 12'h341, 1'b1, 32'h1111_2222, 32'h0, 6'd0);
    chk("ill_exc",   32'(wb_exc), 32'(EXC_ILLEGAL));
    chk("ill_pc",    wb_exc_pc, 32'h8000_0010);
    chk("ill_addr",  wb_exc_addr, 32'hFFFF_FFFF);
    chk("ill_write", 32'(wb_write), 32'd0);
    chk("ill_flush", 32'(flush), 32'd1);
    step();
    set_idle();
    chk("ill_young_killed", 32'(wb_write), 32'd0);
    step();
    chk("ill_young_killed2", 32'(wb_write), 32'd0);
    step();

    // LSU fault merged at E2, then an early ECALL outranking it
    drive_instr(32'h8000_0100, 12'h300, 1'b1, 32'h5, 32'h0, 6'd0);
    step();
    set_idle();
    lsu_exc = EXC_FAULT_LOAD; lsu_addr = 32'h0000_1234;
    step();
    set_idle();
    chk("lsu_exc",  32'(wb_exc), 32'(EXC_FAULT_LOAD));
    chk("lsu_addr", wb_exc_addr, 32'h0000_1234);
    chk("lsu_write", 32'(wb_write), 32'd0);
    step();
    drive_instr(32'h8000_0104, 12'h000, 1'b0, 32'h0, 32'h0, EXC_ECALL);
    step();
    set_idle();
    lsu_exc = EXC_FAULT_LOAD; lsu_addr = 32'h0000_1234;
    step();
    set_idle();
    chk("ecall_exc",  32'(wb_exc), 32'(EXC_ECALL));
    chk("ecall_addr", wb_exc_addr, 32'd0);
    chk("ecall_pc",   wb_exc_pc, 32'h8000_0104);
    step();

    // Stall for three cycles; LSU fault present only while stalled
    drive_instr(32'h8000_0200, 12'h301, 1'b1, 32'hCAFE_0001, 32'h0, 6'd0);
    step();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; lsu_exc = EXC_FAULT_LOAD; lsu_addr = 32'hDEAD_0000;
      step();
      chk("stall_no_pulse", 32'(wb_write), 32'd0);
    end
    set_idle();
    step();
    chk("stall_release_write", 32'(wb_write), 32'd1);
    chk("stall_release_exc",   32'(wb_exc), 32'd0);
    chk("stall_release_wdata", wb_wdata, 32'hCAFE_0001);
    step();
    chk("stall_one_pulse", 32'(wb_write), 32'd0);

    // Interrupt taken at E2, then a squashed instruction
    drive_instr(32'h8000_0040, 12'h300, 1'b1, 32'h7, 32'h0, 6'd0);
    step();
    set_idle();
    irq = 1'b1;
    step();
    set_idle();
    chk("irq_exc",  32'(wb_exc), 32'(EXC_INTERRUPT));
    chk("irq_pc",   wb_exc_pc, 32'h8000_0040);
    chk("irq_addr", wb_exc_addr, 32'd0);
    step();
    drive_instr(32'h8000_0044, 12'h300, 1'b1, 32'h9, 32'h0, 6'd0);
    squash = 1'b1;
    step();
    set_idle();
    step();
    chk("squash_write", 32'(wb_write), 32'd0);
    chk("squash_exc",   32'(wb_exc), 32'd0);

    // Perf counter: five clean retires from reset, then reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_instr(32'h8000_0300 + 32'(i * 4), 12'h340, 1'b1, 32'(i), 32'h0, 6'd0);
      step();
    end
    set_idle();
    for (int i = 0; i < 3; i++) step();
    chk("perf_five", perf, PERF_EN ? 32'd5 : 32'd0);
    drive_instr(32'h8000_0400, 12'h340, 1'b1, 32'h1, 32'h0, 6'd0);
    step();
    drive_instr(32'h8000_0404, 12'h340, 1'b1, 32'h2, 32'h0, 6'd0);
    step();
    set_idle();
    rst = 1'b1;
    step();
    chk("rst_write", 32'(wb_write), 32'd0);
    chk("rst_perf",  perf, 32'd0);
    chk("rst_exc",   32'(wb_exc), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_no_pending", 32'(wb_write), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
